haze_pass_controller: RTL

HAZE_PASS_CONTROLLER -- requirements
Module: haze_pass_controller

---
 rtl/haze_pass_controller_pkg.sv | 22 ++
 rtl/haze_pass_controller_if.sv | 43 ++++
 rtl/haze_pass_controller_pixel_counter.sv | 47 ++++
 rtl/haze_pass_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/haze_pass_controller_pkg.sv
// Shared types and default geometry for the haze-removal pass controller.
package haze_ctrl_pkg;

  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_CNT_W      = 18;

  // Frame sequencing: statistics pass, ALE settle, correction pass, output drain.
  typedef enum logic [2:0] {
    IDLE,
    PASS1,
    ALE_WAIT,
    PASS2,
    DRAIN
  } state_t;

  // Coordinate width; a one-pixel dimension still gets a one-bit field.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/haze_pass_controller_if.sv
// Stream, datapath and ALE handshake bundle of the pass controller.
interface haze_pass_controller_if
  import haze_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
);

  localparam int XW = coord_w(IMG_WIDTH);
  localparam int YW = coord_w(IMG_HEIGHT);

  logic          enable;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          dp_ready;
  logic          pass_sel;
  logic          ale_clear;
  logic          ale_finalize;
  logic          ale_valid;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_done;
  logic          err_tlast;

  // Controller side.
  modport slave (
    input  enable, s_tvalid, s_tlast, dp_ready, ale_valid, m_tvalid, m_tready,
    output s_tready, pass_sel, ale_clear, ale_finalize, m_tlast, pix_x, pix_y,
           frame_done, err_tlast
  );

  // Environment side: source stream, datapath, ALE and sink.
  modport master (
    output enable, s_tvalid, s_tlast, dp_ready, ale_valid, m_tvalid, m_tready,
    input  s_tready, pass_sel, ale_clear, ale_finalize, m_tlast, pix_x, pix_y,
           frame_done, err_tlast
  );

endinterface

// File: rtl/haze_pass_controller_pixel_counter.sv
// Raster position tracker: column, row and linear beat index of the next beat.
module pixel_counter #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int CNT_W  = 4,
  parameter int XW     = 2,
  parameter int YW     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  output logic [CNT_W-1:0] count,
  output logic             at_last
);

  localparam int               TOTAL  = WIDTH * HEIGHT;
  localparam logic [XW-1:0]    X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]    Y_LAST = YW'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TOTAL - 1);

  assign at_last = (count == C_LAST);

  // Step the raster position per accepted beat; a clear wins over a same-cycle beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
    end else if (clear) begin
      x     <= '0;
      y     <= '0;
      count <= '0;
    end else if (inc) begin
      count <= at_last ? '0 : count + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/haze_pass_controller.sv
// Two-pass frame sequencer: ALE statistics pass, then TE/SRSC correction pass.
// Frame length comes from the beat count; TLAST is only cross-checked.
// CNT_W must satisfy 2**CNT_W >= IMG_WIDTH*IMG_HEIGHT.
module haze_pass_controller
  import haze_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  haze_pass_controller_if.slave bus
);

  localparam int XW = coord_w(IMG_WIDTH);
  localparam int YW = coord_w(IMG_HEIGHT);

  state_t state_q, state_d;

  logic             s_ready;
  logic             pass_sel;
  logic             out_active;
  logic             in_beat;
  logic             out_beat;
  logic             in_clear;
  logic             out_clear;
  logic             clear_pulse_d, final_pulse_d, done_pulse_d;
  logic             ale_clear_q, ale_final_q, frame_done_q, err_tlast_q;

  logic [XW-1:0]    in_x, out_x;
  logic [YW-1:0]    in_y, out_y;
  logic [CNT_W-1:0] in_count, out_count;
  logic             in_at_last, out_at_last;
  logic             unused_cnt;

  // Per-state stream gating; s_tready follows dp_ready combinationally in PASS2.
  always_comb begin
    s_ready    = 1'b0;
    pass_sel   = 1'b0;
    out_active = 1'b0;
    unique case (state_q)
      PASS1:   s_ready = 1'b1;
      PASS2: begin
        s_ready    = bus.dp_ready;
        pass_sel   = 1'b1;
        out_active = 1'b1;
      end
      DRAIN: begin
        pass_sel   = 1'b1;
        out_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_beat  = bus.s_tvalid & s_ready;
  assign out_beat = bus.m_tvalid & bus.m_tready & out_active;

  // Next-state logic plus the single-cycle strobes raised on each transition.
  // NOTE: every always_comb output gets a default before the case, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    state_d       = state_q;
    in_clear      = 1'b0;
    out_clear     = 1'b0;
    clear_pulse_d = 1'b0;
    final_pulse_d = 1'b0;
    done_pulse_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d       = PASS1;
          in_clear      = 1'b1;
          clear_pulse_d = 1'b1;
        end
      end
      PASS1: begin
        if (in_beat && in_at_last) begin
          state_d       = ALE_WAIT;
          final_pulse_d = 1'b1;
        end
      end
      ALE_WAIT: begin
        if (bus.ale_valid) begin
          state_d   = PASS2;
          in_clear  = 1'b1;
          out_clear = 1'b1;
        end
      end
      PASS2: begin
        if (in_beat && in_at_last) begin
          // A zero-latency datapath can finish both sides in the same beat.
          if (out_beat && out_at_last) begin
            state_d      = IDLE;
            done_pulse_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_beat && out_at_last) begin
          state_d      = IDLE;
          done_pulse_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, registered strobes and the sticky TLAST cross-check.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      ale_clear_q  <= 1'b0;
      ale_final_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_tlast_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ale_clear_q  <= clear_pulse_d;
      ale_final_q  <= final_pulse_d;
      frame_done_q <= done_pulse_d;
      if (in_beat && (bus.s_tlast != in_at_last)) begin
        err_tlast_q <= 1'b1;
      end
    end
  end

  pixel_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT),
    .CNT_W (CNT_W),
    .XW    (XW),
    .YW    (YW)
  ) u_in_cnt (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (in_clear),
    .inc    (in_beat),
    .x      (in_x),
    .y      (in_y),
    .count  (in_count),
    .at_last(in_at_last)
  );

  pixel_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT),
    .CNT_W (CNT_W),
    .XW    (XW),
    .YW    (YW)
  ) u_out_cnt (
    .clk    (ACLK),
    .rst    (ARESET),
    .clear  (out_clear),
    .inc    (out_beat),
    .x      (out_x),
    .y      (out_y),
    .count  (out_count),
    .at_last(out_at_last)
  );

  // Only the end-of-frame flag of the output tracker and the input raster are consumed.
  assign unused_cnt = ^{in_count, out_x, out_y, out_count};

  assign bus.s_tready     = s_ready;
  assign bus.pass_sel     = pass_sel;
  assign bus.ale_clear    = ale_clear_q;
  assign bus.ale_finalize = ale_final_q;
  assign bus.m_tlast      = out_active & out_at_last;
  assign bus.pix_x        = in_x;
  assign bus.pix_y        = in_y;
  assign bus.frame_done   = frame_done_q;
  assign bus.err_tlast    = err_tlast_q;

endmodule
